// File: rtl/alu_ex_stage_if.sv
// Handshake/data bundle between the ALU execute stage and its neighbours.
// master: the side that drives operations in and consumes results.
// slave: the ALU stage itself.
interface alu_ex_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_ovf
  );
endinterface

// File: rtl/alu_ex_stage.sv
// ALU execute stage: a combinational 32-bit ALU feeding a 2-entry result FIFO.
// in_ready depends on registered state only, so out_ready never reaches it
// combinationally.
module alu_ex_stage (
  input  logic          clk,
  input  logic          reset,
  alu_ex_stage_if.slave bus
);
  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        ovf;
  } ent_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  logic [31:0] w_sum, w_diff, w_res;
  logic        w_add_ovf, w_sub_ovf, w_ovf;
  logic        w_push, w_pop;

  ent_t        r_mem [2];
  logic        r_wptr, r_rptr;
  logic [1:0]  r_count;
  // Held low through reset and set on the first edge after release, so
  // in_ready stays low while reset is asserted.
  logic        r_live;

  assign w_sum     = bus.in_a + bus.in_b;
  assign w_diff    = bus.in_a - bus.in_b;
  assign w_add_ovf = (bus.in_a[31] == bus.in_b[31]) && (w_sum[31]  != bus.in_a[31]);
  assign w_sub_ovf = (bus.in_a[31] != bus.in_b[31]) && (w_diff[31] != bus.in_a[31]);

  // ALU result and overflow flag for the operation presented this cycle
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (bus.in_op)
      OP_ADD:  begin w_res = w_sum;  w_ovf = w_add_ovf; end
      OP_SUB:  begin w_res = w_diff; w_ovf = w_sub_ovf; end
      OP_AND:  w_res = bus.in_a & bus.in_b;
      OP_OR:   w_res = bus.in_a | bus.in_b;
      OP_NOR:  w_res = ~(bus.in_a | bus.in_b);
      // overflow-corrected sign of a-b gives the signed less-than
      OP_SLT:  w_res = {31'd0, w_diff[31] ^ w_sub_ovf};
      OP_SLTU: w_res = {31'd0, (bus.in_a < bus.in_b)};
      OP_XOR:  w_res = bus.in_a ^ bus.in_b;
      default: w_res = '0;
    endcase
  end

  assign bus.in_ready   = r_live && (r_count != 2'd2);
  assign bus.out_valid  = (r_count != 2'd0);
  assign w_push         = bus.in_valid && bus.in_ready;
  assign w_pop          = bus.out_valid && bus.out_ready;

  assign bus.out_result = r_mem[r_rptr].result;
  assign bus.out_zero   = r_mem[r_rptr].zero;
  assign bus.out_ovf    = r_mem[r_rptr].ovf;

  // FIFO storage, pointers and occupancy; reset clears entries so outputs read 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_live  <= 1'b0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_push) begin
        r_mem[r_wptr] <= '{result: w_res, zero: (w_res == 32'd0), ovf: w_ovf};
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ex_stage.sv
// Randomized bench for alu_ex_stage: a queue-based reference model with
// integer arithmetic predicts every handshake and head-of-FIFO value.
module tb_alu_ex_stage;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         NOR_ = 3'd4, SLT = 3'd5, SLTU = 3'd6, XOR_ = 3'd7;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic clk;
  logic reset;
  int   n_chk, n_pass, n_acc;
  exp_t q[$];

  alu_ex_stage_if bus ();

  alu_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic exp_t ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, r;
    longint maxi, mini;
    maxi = 64'sd2147483647;
    mini = -64'sd2147483648;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    e.ovf = 1'b0;
    case (op)
      ADD:  begin r = sa + sb; e.result = r[31:0]; e.ovf = (r > maxi) || (r < mini); end
      SUB:  begin r = sa - sb; e.result = r[31:0]; e.ovf = (r > maxi) || (r < mini); end
      AND_: e.result = a & b;
      OR_:  e.result = a | b;
      NOR_: e.result = ~(a | b);
      SLT:  e.result = (sa < sb) ? 32'd1 : 32'd0;
      SLTU: e.result = (a < b) ? 32'd1 : 32'd0;
      default: e.result = a ^ b;
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(7, 0))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One cycle: drive inputs, check against the model at the falling edge,
  // then advance the model by what the coming rising edge does.
  task automatic step(input bit v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input bit ordy);
    bit acc, pop;
    bus.in_valid = v; bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.out_ready = ordy;
    @(negedge clk);
    chk("in_ready", bus.in_ready, q.size() < 2);
    chk("out_valid", bus.out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("result", bus.out_result, q[0].result);
      chk("zero", bus.out_zero, q[0].zero);
      chk("ovf", bus.out_ovf, q[0].ovf);
    end
    acc = v && (q.size() < 2);
    pop = ordy && (q.size() > 0);
    if (pop) void'(q.pop_front());
    if (acc) begin q.push_back(ref_alu(op, a, b)); n_acc++; end
    @(posedge clk); #1;
  endtask

  task automatic peek(input string tag, input bit v, input logic [31:0] res,
                      input bit z, input bit o);
    chk({tag, "_valid"}, bus.out_valid, v);
    if (v) begin
      chk({tag, "_result"}, bus.out_result, res);
      chk({tag, "_zero"}, bus.out_zero, z);
      chk({tag, "_ovf"}, bus.out_ovf, o);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(0, ADD, 0, 0, 1);
  endtask

  // Assert reset between edges, check the asynchronous clear, release it.
  task automatic do_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_result", bus.out_result, 0);
    chk("rst_zero", bus.out_zero, 0);
    chk("rst_ovf", bus.out_ovf, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    chk("rel_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("post_rst_ready", bus.in_ready, 1);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_acc = 0;
    reset = 1'b1;
    bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_op = 0; bus.out_ready = 0;
    do_reset();

    // signed compare across the sign boundary
    step(1, SLT, 32'h8000_0000, 32'h1, 1);
    peek("slt_neg", 1, 32'd1, 0, 0);
    step(1, SLT, 32'h1, 32'hFFFF_FFFF, 1);
    peek("slt_pos", 1, 32'd0, 1, 0);
    drain();

    // overflow corners and unsigned compare
    step(1, ADD, 32'h7FFF_FFFF, 32'h1, 1);
    peek("add_ovf", 1, 32'h8000_0000, 0, 1);
    step(1, SUB, 32'h8000_0000, 32'h1, 1);
    peek("sub_ovf", 1, 32'h7FFF_FFFF, 0, 1);
    step(1, SLTU, 32'h1, 32'hFFFF_FFFF, 1);
    peek("sltu", 1, 32'd1, 0, 0);
    drain();

    // fill to full with the consumer stalled, then release
    step(1, ADD, 32'd1, 32'd2, 0);
    step(1, SUB, 32'd5, 32'd5, 0);
    chk("full_in_ready", bus.in_ready, 0);
    step(1, OR_, 32'd4, 32'd8, 0);
    peek("full_head", 1, 32'd3, 0, 0);
    step(1, OR_, 32'd4, 32'd8, 1);
    peek("second", 1, 32'd0, 1, 0);
    chk("refill_ready", bus.in_ready, 1);
    step(1, OR_, 32'd4, 32'd8, 1);
    peek("third", 1, 32'd12, 0, 0);
    drain();

    // steady state at count 1: accept and pop on every edge
    step(1, logic'(3'($urandom_range(7, 0))), pick(), pick(), 0);
    for (int i = 0; i < 100; i++) begin
      step(1, 3'($urandom_range(7, 0)), pick(), pick(), 1);
      chk("cnt1_valid", bus.out_valid, 1);
      chk("cnt1_ready", bus.in_ready, 1);
    end
    drain();

    // reset while full, then a first op after release
    step(1, ADD, 32'd7, 32'd9, 0);
    step(1, XOR_, 32'hF0F0, 32'h0FF0, 0);
    peek("prefull", 1, 32'd16, 0, 0);
    do_reset();
    step(1, NOR_, 32'd0, 32'd0, 0);
    peek("nor_after_rst", 1, 32'hFFFF_FFFF, 0, 0);
    drain();

    // random traffic on both sides
    n_acc = 0;
    for (int cyc = 0; cyc < 40000 && n_acc < 10000; cyc++)
      step($urandom_range(9, 0) < 7, 3'($urandom_range(7, 0)), pick(), pick(),
           $urandom_range(9, 0) < 6);
    chk("random_accepts", n_acc, 10000);
    drain();
    chk("final_empty", bus.out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_ex_stage.md
ALU_EX_STAGE -- requirements
Module: alu_ex_stage

Interface
REQ-001 SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  upstream presents an operation this cycle.
REQ-005 in_ready  output  1  block accepts an operation this cycle.
REQ-006 in_a  input  32  operand A, two's complement.
REQ-007 in_b  input  32  operand B, two's complement.
REQ-008 in_op  input  3  operation code: 000 add, 001 sub, 010 and, 011 or, 100 nor, 101 slt, 110 sltu, 111 xor.
REQ-009 out_valid  output  1  head result entry is valid.
REQ-010 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-011 out_result  output  32  head result value.
REQ-012 out_zero  output  1  head result equals 0.
REQ-013 out_ovf  output  1  signed overflow for add/sub; 0 for all other ops.

Function
REQ-014 SHALL accept an operation on a rising edge where in_valid and in_ready are both 1 (accept); no other cycle changes state from the input side.
REQ-015 SHALL compute the result combinationally from in_a, in_b and in_op, then write it with its zero and overflow flags into a 2-entry output FIFO at the accept edge.
REQ-016 Latency: an operation accepted at edge N SHALL be at the FIFO head with out_valid=1 after edge N, provided the FIFO was empty; otherwise it follows in order.
REQ-017 add/sub SHALL use 32-bit wrap-around arithmetic.
REQ-018 out_ovf for add SHALL be 1 when the operand signs match and the result sign differs; for sub, when the operand signs differ and the result sign differs from in_a.
REQ-019 slt SHALL return 32'd1 when in_a < in_b as signed values, else 32'd0.
REQ-020 slt SHALL be correct on subtraction overflow, i.e. the result is sign(a-b) XOR overflow, not the raw difference sign.
REQ-021 sltu SHALL return 32'd1 when in_a < in_b as unsigned values, else 32'd0.
REQ-022 out_zero SHALL equal (result == 0) for every op.
REQ-023 FIFO occupancy count SHALL be 0..2.
REQ-024 in_ready SHALL be 1 when count < 2, registered-state only, with no combinational path from out_ready.
REQ-025 out_valid SHALL be 1 when count > 0.
REQ-026 out_result, out_zero and out_ovf SHALL show the head entry and SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 Pop SHALL occur at an edge where out_valid and out_ready are both 1; the head then advances.
REQ-028 Simultaneous accept and pop SHALL leave count unchanged and preserve order; this is possible only at count 1, since count 0 has nothing to pop and count 2 holds in_ready low.
REQ-029 Full (count 2): in_ready=0 and in_valid is ignored; a pop at that edge makes in_ready=1 on the following cycle.
REQ-030 Empty (count 0): out_ready is ignored, and the output data values are don't-care but held stable.
REQ-031 FIFO pointers SHALL be 1-bit and wrap 1->0.
REQ-032 Results SHALL leave the FIFO in exact acceptance order, with no loss or duplication.

Reset
REQ-033 While reset=1, asynchronously: count=0, pointers=0, out_valid=0, in_ready=0.
REQ-034 After reset deasserts, in_ready SHALL be 1 from the first clock edge onward.
REQ-035 While reset=1, out_result, out_zero and out_ovf SHALL read 0.
REQ-036 Reset mid-operation SHALL discard all buffered entries and any operation presented in that cycle.

Verification
REQ-037 slt accepted with a=32'h8000_0000, b=32'h0000_0001, out_ready=1 -> one cycle later out_valid=1, out_result=1, out_zero=0, out_ovf=0; with a=1, b=-1 -> out_result=0, out_zero=1.
REQ-038 add 32'h7FFF_FFFF + 1 -> out_result=32'h8000_0000, out_ovf=1; sub 32'h8000_0000 - 1 -> out_result=32'h7FFF_FFFF, out_ovf=1; sltu a=1, b=32'hFFFF_FFFF -> out_result=1.
REQ-039 out_ready=0, three back-to-back accept attempts (add 1+2, sub 5-5, or 4|8) -> first two accepted, in_ready=0 on the third; then out_ready=1 -> results 3 (zero=0), 0 (zero=1), then the third op once accepted gives 12.
REQ-040 count=1 with a simultaneous accept and pop for 100 cycles of random ops -> count stays 1, and every result matches the reference model in order.
REQ-041 Reset asserted asynchronously between edges with count=2 -> out_valid drops immediately; after release, first accept of nor 0,0 -> out_result=32'hFFFF_FFFF.
REQ-042 Random in_valid/out_ready traffic over 10k ops checked against a scoreboard -> no loss, duplication or reordering, and outputs stable while stalled.
